// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: frame-granular round-robin arbiter feeding the single AXI-Stream slave port of tx_mac.
//
// Ports:
//   i_clk          clock
//   i_reset_n      asynchronous reset, active high (name kept for compatibility with the existing codebase)
//   s_axis_*       NUM_SRC packed source streams; source k uses slice k of each bus
//   s_axis_trdy    per-source ready, only the granted source sees m_axis_trdy
//   m_axis_*       merged stream towards tx_mac
//   i_pause        blocks new grants; a frame already in flight always completes
//   o_grant        index of the current or last granted source
//   o_busy         high while a frame is being transferred
//   o_frame_cnt    number of completed frames, wrapping
module tx_frame_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [NUM_SRC-1:0]            s_axis_trdy,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_trdy,
    input  logic                          i_pause,
    output logic [$clog2(NUM_SRC)-1:0]    o_grant,
    output logic                          o_busy,
    output logic [CNT_WIDTH-1:0]          o_frame_cnt
);
    localparam int GW = $clog2(NUM_SRC);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]    state;
    logic [GW-1:0] next_grant;
    logic          xfer;

    // Scan downward so the smallest offset after the last grant is assigned last and wins.
    always_comb begin
        next_grant = o_grant;
        for (int i = NUM_SRC; i > 0; i--)
            if (s_axis_tvalid[(int'(o_grant) + i) % NUM_SRC])
                next_grant = GW'((int'(o_grant) + i) % NUM_SRC);
    end

    assign xfer          = (state == XFER);
    assign o_busy        = xfer;
    assign m_axis_tvalid = xfer & s_axis_tvalid[o_grant];
    assign m_axis_tlast  = xfer & s_axis_tlast[o_grant];
    assign m_axis_tdata  = xfer ? s_axis_tdata[o_grant*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_axis_tkeep  = xfer ? s_axis_tkeep[o_grant*KEEP_WIDTH +: KEEP_WIDTH] : '0;
    assign s_axis_trdy   = (xfer & m_axis_trdy) ? (NUM_SRC'(1) << o_grant) : '0;

    // The grant stays locked until the tlast beat is accepted, so frames never interleave.
    always_ff @(posedge i_clk or posedge i_reset_n) begin
        if (i_reset_n) begin
            state       <= IDLE;
            o_grant     <= GW'(NUM_SRC - 1);
            o_frame_cnt <= '0;
        end else if (state == IDLE) begin
            if (!i_pause && |s_axis_tvalid) begin
                o_grant <= next_grant;
                state   <= XFER;
            end
        end else if (m_axis_tvalid && m_axis_trdy && m_axis_tlast) begin
            o_frame_cnt <= o_frame_cnt + 1'b1;
            state       <= IDLE;
        end
    end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: directed self-checking bench for tx_frame_arbiter.
module tb_tx_frame_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int CW = 4;

    logic              i_clk = 1'b0;
    logic              i_reset_n = 1'b1;
    logic [N*DW-1:0]   s_axis_tdata;
    logic [N*KW-1:0]   s_axis_tkeep;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tlast;
    logic [N-1:0]      s_axis_trdy;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_trdy = 1'b1;
    logic              i_pause = 1'b0;
    logic [1:0]        o_grant;
    logic              o_busy;
    logic [CW-1:0]     o_frame_cnt;

    logic [DW-1:0]     src_dat [N];
    logic [KW-1:0]     src_kp  [N];
    logic [N-1:0]      src_vld;
    logic [N-1:0]      src_lst;
    int                frames [N];
    int                len    [N];
    int                beat   [N];
    int                fr     [N];
    logic [36:0]       log_q [$];
    int                checks = 0;
    int                errors = 0;

    always #5 i_clk = ~i_clk;

    genvar g;
    for (g = 0; g < N; g++) begin : g_pack
        assign s_axis_tdata[g*DW +: DW] = src_dat[g];
        assign s_axis_tkeep[g*KW +: KW] = src_kp[g];
    end
    assign s_axis_tvalid = src_vld;
    assign s_axis_tlast  = src_lst;

    tx_frame_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_trdy(s_axis_trdy),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_trdy(m_axis_trdy),
        .i_pause(i_pause), .o_grant(o_grant), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
    );

    // Beat word identifies source, frame and beat so loss, duplication and interleaving all show up.
    function automatic logic [36:0] exp_entry(input int k, input int f, input int b, input int n);
        return {b == n - 1, (b == n - 1) ? 4'h3 : 4'hF, 8'(k), 8'(f), 16'(b)};
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            src_vld[k] = frames[k] > 0;
            src_lst[k] = beat[k] == len[k] - 1;
            src_dat[k] = {8'(k), 8'(fr[k]), 16'(beat[k])};
            src_kp[k]  = src_lst[k] ? 4'h3 : 4'hF;
        end
    endtask

    task automatic setup(input int k, input int n, input int cnt);
        len[k] = n; frames[k] = cnt; fr[k] = 0; beat[k] = 0;
    endtask

    // Samples at the falling edge, then advances the source models past the next rising edge.
    task automatic tick();
        logic [N-1:0] hs;
        #4;
        checks++;
        if ($countones(s_axis_trdy) > 1) begin
            errors++; $display("FAIL trdy_onehot got %b want at most one bit", s_axis_trdy);
        end
        hs = s_axis_tvalid & s_axis_trdy;
        if (m_axis_tvalid && m_axis_trdy) log_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
        @(posedge i_clk); #1;
        for (int k = 0; k < N; k++)
            if (hs[k]) begin
                beat[k]++;
                if (beat[k] == len[k]) begin beat[k] = 0; fr[k]++; frames[k]--; end
            end
        drive();
    endtask

    task automatic test_reset();
        checks++; if (o_grant !== 2'd3) begin errors++; $display("FAIL rst_grant got %0d want 3", o_grant); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", o_busy); end
        checks++; if (o_frame_cnt !== 4'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", o_frame_cnt); end
        checks++; if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, s_axis_trdy} !== '0) begin
            errors++; $display("FAIL rst_outputs got %b/%b/%h/%h/%b want all 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tkeep, s_axis_trdy);
        end
    endtask

    task automatic test_single();
        log_q.delete(); setup(0, 4, 2); drive();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", o_busy); end
        tick();
        checks++; if (o_grant !== 2'd0 || o_busy !== 1'b1) begin errors++; $display("FAIL single_grant got %0d/%b want 0/1", o_grant, o_busy); end
        repeat (4) tick();
        checks++; if (o_busy !== 1'b0 || o_frame_cnt !== 4'd1) begin errors++; $display("FAIL single_end got %b/%0d want 0/1", o_busy, o_frame_cnt); end
        tick();
        checks++; if (o_grant !== 2'd0 || o_busy !== 1'b1) begin errors++; $display("FAIL single_regrant got %0d/%b want 0/1", o_grant, o_busy); end
        repeat (4) tick();
        checks++; if (o_busy !== 1'b0 || o_frame_cnt !== 4'd2) begin errors++; $display("FAIL single_end2 got %b/%0d want 0/2", o_busy, o_frame_cnt); end
        checks++; if (log_q.size() !== 8) begin errors++; $display("FAIL single_beats got %0d want 8", log_q.size()); end
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_entry(0, i / 4, i % 4, 4)) begin
                errors++; $display("FAIL single_beat%0d got %h want %h", i, log_q[i], exp_entry(0, i / 4, i % 4, 4));
            end
        end
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        i_reset_n = 1'b1; log_q.delete();
        for (int k = 0; k < N; k++) setup(k, 2, (k == 0) ? 2 : 1);
        drive(); tick(); i_reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_grant !== 2'(order[i]) || o_busy !== 1'b1) begin
                errors++; $display("FAIL rr_grant%0d got %0d/%b want %0d/1", i, o_grant, o_busy, order[i]);
            end
            repeat (2) tick();
        end
        checks++; if (o_busy !== 1'b0 || o_frame_cnt !== 4'd5) begin errors++; $display("FAIL rr_cnt got %b/%0d want 0/5", o_busy, o_frame_cnt); end
        checks++; if (log_q.size() !== 10) begin errors++; $display("FAIL rr_beats got %0d want 10", log_q.size()); end
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_entry(order[i / 2], i / 8, i % 2, 2)) begin
                errors++; $display("FAIL rr_beat%0d got %h want %h", i, log_q[i], exp_entry(order[i / 2], i / 8, i % 2, 2));
            end
        end
    endtask

    task automatic test_pause();
        log_q.delete(); setup(2, 6, 1); setup(3, 2, 1); drive();
        tick();
        checks++; if (o_grant !== 2'd2 || o_busy !== 1'b1) begin errors++; $display("FAIL pause_grant got %0d/%b want 2/1", o_grant, o_busy); end
        tick();
        i_pause = 1'b1;
        repeat (5) tick();
        checks++; if (o_busy !== 1'b0 || o_frame_cnt !== 4'd6) begin errors++; $display("FAIL pause_frame_done got %b/%0d want 0/6", o_busy, o_frame_cnt); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL pause_hold%0d got %b want 0", i, o_busy); end
        end
        i_pause = 1'b0;
        tick();
        checks++; if (o_grant !== 2'd3 || o_busy !== 1'b1) begin errors++; $display("FAIL pause_release got %0d/%b want 3/1", o_grant, o_busy); end
        repeat (2) tick();
        checks++; if (o_busy !== 1'b0 || o_frame_cnt !== 4'd7) begin errors++; $display("FAIL pause_cnt got %b/%0d want 0/7", o_busy, o_frame_cnt); end
        checks++; if (log_q.size() !== 8) begin errors++; $display("FAIL pause_beats got %0d want 8", log_q.size()); end
        for (int i = 0; i < 8 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== ((i < 6) ? exp_entry(2, 0, i, 6) : exp_entry(3, 0, i - 6, 2))) begin
                errors++; $display("FAIL pause_beat%0d got %h", i, log_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        log_q.delete(); setup(1, 4, 1); drive();
        tick();
        checks++; if (o_grant !== 2'd1 || o_busy !== 1'b1) begin errors++; $display("FAIL bp_grant got %0d/%b want 1/1", o_grant, o_busy); end
        for (int i = 0; i < 8; i++) begin
            m_axis_trdy = (i % 2 == 0);
            #2;
            checks++;
            if (s_axis_trdy !== (m_axis_trdy ? 4'b0010 : 4'b0000)) begin
                errors++; $display("FAIL bp_trdy%0d got %b want %b", i, s_axis_trdy, m_axis_trdy ? 4'b0010 : 4'b0000);
            end
            tick();
        end
        m_axis_trdy = 1'b1;
        checks++; if (o_busy !== 1'b0 || o_frame_cnt !== 4'd8) begin errors++; $display("FAIL bp_cnt got %b/%0d want 0/8", o_busy, o_frame_cnt); end
        checks++; if (log_q.size() !== 4) begin errors++; $display("FAIL bp_beats got %0d want 4", log_q.size()); end
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_entry(1, 0, i, 4)) begin errors++; $display("FAIL bp_beat%0d got %h want %h", i, log_q[i], exp_entry(1, 0, i, 4)); end
        end
    endtask

    task automatic test_reset_midframe();
        log_q.delete(); setup(0, 6, 1); drive();
        tick();
        checks++; if (o_grant !== 2'd0 || o_busy !== 1'b1) begin errors++; $display("FAIL mid_grant got %0d/%b want 0/1", o_grant, o_busy); end
        repeat (2) tick();
        i_reset_n = 1'b1;
        #1;
        test_reset();
        tick();
        i_reset_n = 1'b0;
        tick();
        checks++; if (o_grant !== 2'd0 || o_busy !== 1'b1) begin errors++; $display("FAIL mid_regrant got %0d/%b want 0/1", o_grant, o_busy); end
        repeat (4) tick();
        checks++; if (o_busy !== 1'b0 || o_frame_cnt !== 4'd1) begin errors++; $display("FAIL mid_cnt got %b/%0d want 0/1", o_busy, o_frame_cnt); end
        checks++; if (log_q.size() !== 6) begin errors++; $display("FAIL mid_beats got %0d want 6", log_q.size()); end
        for (int i = 0; i < 6 && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_entry(0, 0, i, 6)) begin errors++; $display("FAIL mid_beat%0d got %h want %h", i, log_q[i], exp_entry(0, 0, i, 6)); end
        end
    endtask

    task automatic test_wrap();
        log_q.delete(); setup(3, 1, 15); drive();
        repeat (28) tick();
        checks++; if (o_busy !== 1'b0 || o_frame_cnt !== 4'hF) begin errors++; $display("FAIL wrap_max got %b/%0d want 0/15", o_busy, o_frame_cnt); end
        repeat (2) tick();
        checks++; if (o_frame_cnt !== 4'h0) begin errors++; $display("FAIL wrap_zero got %0d want 0", o_frame_cnt); end
        checks++; if (o_grant !== 2'd3 || log_q.size() !== 15) begin errors++; $display("FAIL wrap_src got %0d/%0d want 3/15", o_grant, log_q.size()); end
    endtask

    initial begin
        for (int k = 0; k < N; k++) setup(k, 1, 0);
        drive();
        repeat (3) @(posedge i_clk);
        #1;
        test_reset();
        i_reset_n = 1'b0;
        test_single();
        test_round_robin();
        test_pause();
        test_backpressure();
        test_reset_midframe();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
